rr_bus_arbiter4: RTL

- Round-robin arbiter that shares one 32-bit bus port between four requesters.
- It sequences the 4:1 32-bit data mux by driving its 2-bit select and qualifying the muxed output with a valid/ack handshake.
- Sits between pipeline-side requesters (e.g. IF, MEM, debug, DMA) and a single slave port such as unified memory or a peripheral bus.
- Includes a per-transaction timeout so a dead slave cannot lock the bus.

---
 rtl/rr_bus_arbiter4_pkg.sv | 14 +
 rtl/MUX4T1_32.sv | 21 ++
 rtl/rr_bus_arbiter4.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rr_bus_arbiter4_pkg.sv
// rtl/rr_bus_arbiter4_pkg.sv - shared types and constants for the 4-way round-robin bus arbiter
package rr_bus_arbiter4_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int         NREQ     = 4;
  localparam int         DATA_W   = 32;
  // Starting from 3 makes requester 0 the first winner after reset
  localparam logic [1:0] LAST_RST = 2'd3;

endpackage

// File: rtl/MUX4T1_32.sv
// rtl/MUX4T1_32.sv - 4:1 multiplexer for 32-bit words
module MUX4T1_32 (
  input  logic [31:0] i_d0,
  input  logic [31:0] i_d1,
  input  logic [31:0] i_d2,
  input  logic [31:0] i_d3,
  input  logic [1:0]  i_sel,
  output logic [31:0] o_y
);

  // Pure combinational select
  always_comb begin
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

// File: rtl/rr_bus_arbiter4.sv
// rtl/rr_bus_arbiter4.sv - round-robin arbiter sharing one 32-bit bus port among four requesters
module rr_bus_arbiter4
  import rr_bus_arbiter4_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_req,
  input  logic [31:0] i_i0,
  input  logic [31:0] i_i1,
  input  logic [31:0] i_i2,
  input  logic [31:0] i_i3,
  input  logic        i_bus_ack,
  output logic [3:0]  o_grant,
  output logic [1:0]  o_sel,
  output logic        o_bus_valid,
  output logic [31:0] o_bus_data,
  output logic [3:0]  o_done,
  output logic [3:0]  o_err
);

  state_t             r_state;
  logic [NREQ-1:0]    r_grant;
  logic [1:0]         r_sel;
  logic [1:0]         r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [NREQ-1:0]    r_done;
  logic [NREQ-1:0]    r_err;

  state_t             w_state_n;
  logic [NREQ-1:0]    w_grant_n;
  logic [1:0]         w_sel_n;
  logic [1:0]         w_last_n;
  logic [CNT_W-1:0]   w_cnt_n;
  logic [NREQ-1:0]    w_done_n;
  logic [NREQ-1:0]    w_err_n;
  logic [1:0]         w_winner;
  logic [DATA_W-1:0]  w_mux;

  // First set request bit scanning upward from the slot after the last owner;
  // the last owner is visited last, which is what gives it lowest priority.
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // State register; reset drops the grant immediately and forgets the transfer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_sel   <= 2'd0;
      r_last  <= LAST_RST;
      r_cnt   <= '0;
      r_done  <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_n;
      r_grant <= w_grant_n;
      r_sel   <= w_sel_n;
      r_last  <= w_last_n;
      r_cnt   <= w_cnt_n;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
    end
  end

  // Next-state logic: arbitrate in IDLE; in BUSY resolve ack > timeout > abort
  always_comb begin
    w_state_n = r_state;
    w_grant_n = r_grant;
    w_sel_n   = r_sel;
    w_last_n  = r_last;
    w_cnt_n   = r_cnt;
    w_done_n  = '0;
    w_err_n   = '0;
    w_winner  = rr_pick(i_req, r_last);
    case (r_state)
      ST_IDLE: begin
        if (|i_req) begin
          w_state_n = ST_BUSY;
          w_grant_n = 4'b0001 << w_winner;
          w_sel_n   = w_winner;
          w_cnt_n   = '0;
        end
      end
      ST_BUSY: begin
        if (i_bus_ack) begin
          w_done_n[r_sel] = 1'b1;
          w_grant_n       = '0;
          w_last_n        = r_sel;
          w_state_n       = ST_IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_err_n[r_sel]  = 1'b1;
          w_grant_n       = '0;
          w_last_n        = r_sel;
          w_state_n       = ST_IDLE;
        end else if (!i_req[r_sel]) begin
          w_grant_n       = '0;
          w_last_n        = r_sel;
          w_state_n       = ST_IDLE;
        end else begin
          w_cnt_n         = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_grant_n = '0;
      end
    endcase
  end

  MUX4T1_32 u_mux (
    .i_d0  (i_i0),
    .i_d1  (i_i1),
    .i_d2  (i_i2),
    .i_d3  (i_i3),
    .i_sel (r_sel),
    .o_y   (w_mux)
  );

  assign o_grant     = r_grant;
  assign o_sel       = r_sel;
  assign o_bus_valid = |r_grant;
  assign o_bus_data  = w_mux & {DATA_W{o_bus_valid}};
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule
